frame_reader: RTL and testbench
===============================

Name: frame_reader

Overview:
- Consumer side of the animation frame-memory interface. Raster-scans a frame by driving ram_addr_x/ram_addr_y into a frame memory with combinational read. Captures each returned pixel into a registered output stage with a valid/ready handshake toward the panel driver.
- One start pulse reads exactly one full frame. A frame_done pulse lets the animation controller advance to its next frame.

Parameters:
- WIDTH, 128, pixels per line; range 1..256.
- HEIGHT, 160, lines per frame; range 1..256.
- PIX_W, 16, pixel width in bits; must match ram_data.

Ports:
- clk_24  input  1  block clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request one frame read; sampled only in IDLE.
- ram_addr_x  output  8  column address to frame memory; registered.
- ram_addr_y  output  8  row address to frame memory; registered.
- ram_data  input  PIX_W  pixel at (ram_addr_x, ram_addr_y); combinational, valid in the same cycle as the address.
- pix_data  output  PIX_W  registered pixel to the driver.
- pix_valid  output  1  pix_data and the flags are valid.
- pix_ready  input  1  driver accepts the pixel when pix_valid && pix_ready.
- pix_sof  output  1  current pixel is (0,0).
- pix_eol  output  1  current pixel has x = WIDTH-1.
- pix_eof  output  1  current pixel is (WIDTH-1, HEIGHT-1).
- busy  output  1  high in FETCH and DRAIN.
- frame_done  output  1  one-cycle pulse when the last pixel is accepted.

Behaviour:
- Reset (async, any state): state=IDLE; ram_addr_x=0, ram_addr_y=0, pix_data=0; pix_valid, pix_sof, pix_eol, pix_eof, busy, frame_done all 0.
- State machine IDLE / FETCH / DRAIN:
  - IDLE: addresses held at (0,0); pix_valid=0. start=1 at an edge moves to FETCH.
  - FETCH: define load = !pix_valid || pix_ready. On an edge with load=1:
    - pix_data <= ram_data; pix_valid <= 1.
    - pix_sof/eol/eof <= computed from the current address.
    - Address advances: x+1; if x=WIDTH-1 then x=0, y+1.
    - If the loaded address is (WIDTH-1, HEIGHT-1): addresses return to (0,0) and state moves to DRAIN.
  - FETCH with load=0 (stall): address, pix_data and flags hold. No pixel is dropped or duplicated.
  - DRAIN: hold the last pixel until pix_valid && pix_ready. On that edge: pix_valid=0, flags=0, frame_done=1 for exactly one cycle, state moves to IDLE.
- busy is registered: 1 in FETCH and DRAIN, 0 in IDLE.
- Latency and throughput:
  - start sampled at edge N puts the state in FETCH after N.
  - Pixel (0,0) becomes valid after edge N+1.
  - With pix_ready held at 1: one pixel per cycle, WIDTH*HEIGHT consecutive valid cycles.
  - frame_done asserts after edge N+1+WIDTH*HEIGHT.
- start while busy is ignored; there is no queuing.
- start on the same edge frame_done asserts is ignored, because the state is still DRAIN at that edge. start on the next edge begins a new frame.
- WIDTH=1 and/or HEIGHT=1 are legal:
  - WIDTH=1: every pixel has eol=1.
  - WIDTH=HEIGHT=1: the single pixel carries sof, eol and eof together and the block goes straight to DRAIN.
- pix_ready toggling arbitrarily must never change pix_data or the flags while pix_valid=1 and pix_ready=0.
- Address counters compare only to the WIDTH-1 and HEIGHT-1 limits. Coordinates beyond the frame are never emitted, even for WIDTH=256.
- rst asserted mid-frame aborts immediately to the reset values. No frame_done is produced for an aborted frame.

Test Plan:
- WIDTH=4, HEIGHT=3, ram_data={y,x}, pix_ready=1, start pulse at edge 0 -> pixels valid after edges 1..12 in raster order 0x0000,0x0001..0x0203. Flags: sof on the first pixel; eol on x=3; eof only on 0x0203. frame_done after edge 13; busy=0 after.
- Same setup, pix_ready low for 3 cycles while pixel 0x0102 is valid -> pix_data, flags and address stable for those 3 cycles; 0x0103 follows next; exactly 12 accepted transfers.
- start held high across the whole frame -> the first frame completes normally. A new frame begins only once the state is back in IDLE: start sampled on the edge after frame_done asserts (state IDLE), (0,0) reloads after the following edge.
- WIDTH=1, HEIGHT=1 -> a single pixel with sof=eol=eof=1. frame_done after its acceptance; addresses back at (0,0).
- rst asserted asynchronously mid-cycle at pixel 5 -> all outputs zero immediately, no frame_done. A later start reads the frame from (0,0).
- Random pix_ready (50%) over a 128x160 frame -> the accepted sequence equals the 20480-pixel raster order. frame_done occurs exactly once.

Source files
------------

// File: rtl/frame_reader_if.sv
// Frame-memory read bus plus pixel stream toward the panel driver.
//   ram_addr_x/ram_addr_y : column/row address into the frame memory
//   ram_data              : pixel at that address, combinational
//   pix_data/pix_valid/pix_ready : registered pixel with valid/ready handshake
//   pix_sof/pix_eol/pix_eof      : first pixel, last pixel of line, last pixel of frame
// master = frame_reader side, slave = memory/driver side.
interface frame_reader_if #(
  parameter int unsigned PIX_W = 16
);
  logic [7:0]       ram_addr_x;
  logic [7:0]       ram_addr_y;
  logic [PIX_W-1:0] ram_data;
  logic [PIX_W-1:0] pix_data;
  logic             pix_valid;
  logic             pix_ready;
  logic             pix_sof;
  logic             pix_eol;
  logic             pix_eof;

  modport master (
    output ram_addr_x, ram_addr_y,
    input  ram_data,
    output pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
    input  pix_ready
  );

  modport slave (
    input  ram_addr_x, ram_addr_y,
    output ram_data,
    input  pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
    output pix_ready
  );
endinterface

// File: rtl/frame_reader.sv
// Raster-scan frame reader. One start pulse reads exactly one WIDTH x HEIGHT frame from a
// combinational-read frame memory and presents each pixel on a registered valid/ready stage.
//   clk_24     : clock, rising edge
//   rst        : asynchronous, active-high reset
//   start      : request one frame read, sampled only while idle
//   bus        : frame_reader_if.master (memory address/data, pixel stream and flags)
//   busy       : registered, high while fetching or draining a frame
//   frame_done : one-cycle pulse after the last pixel of a frame is accepted
module frame_reader #(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned HEIGHT = 160,
  parameter int unsigned PIX_W  = 16
) (
  input  logic           clk_24,
  input  logic           rst,
  input  logic           start,
  frame_reader_if.master bus,
  output logic           busy,
  output logic           frame_done
);

  localparam logic [7:0] XMax = 8'(WIDTH - 1);
  localparam logic [7:0] YMax = 8'(HEIGHT - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e           state_q, state_d;
  logic [7:0]       x_q, x_d;
  logic [7:0]       y_q, y_d;
  logic [PIX_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             sof_q, sof_d;
  logic             eol_q, eol_d;
  logic             eof_q, eof_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic load;
  logic last_x;
  logic last_y;

  // Output stage can take a new pixel when empty or when the current one leaves this edge.
  assign load   = !valid_q || bus.pix_ready;
  assign last_x = (x_q == XMax);
  assign last_y = (y_q == YMax);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    data_d  = data_q;
    valid_d = valid_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    eof_d   = eof_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        x_d = 8'd0;
        y_d = 8'd0;
        if (start) begin
          state_d = StFetch;
          busy_d  = 1'b1;
        end
      end
      StFetch: begin
        if (load) begin
          data_d  = bus.ram_data;
          valid_d = 1'b1;
          sof_d   = (x_q == 8'd0) && (y_q == 8'd0);
          eol_d   = last_x;
          eof_d   = last_x && last_y;
          if (last_x) begin
            x_d = 8'd0;
            if (last_y) begin
              // Last pixel loaded: rewind and wait for it to be taken.
              y_d     = 8'd0;
              state_d = StDrain;
            end else begin
              y_d = y_q + 8'd1;
            end
          end else begin
            x_d = x_q + 8'd1;
          end
        end
      end
      StDrain: begin
        if (valid_q && bus.pix_ready) begin
          valid_d = 1'b0;
          sof_d   = 1'b0;
          eol_d   = 1'b0;
          eof_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_24 or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= 8'd0;
      y_q     <= 8'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.ram_addr_x = x_q;
  assign bus.ram_addr_y = y_q;
  assign bus.pix_data   = data_q;
  assign bus.pix_valid  = valid_q;
  assign bus.pix_sof    = sof_q;
  assign bus.pix_eol    = eol_q;
  assign bus.pix_eof    = eof_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;

endmodule

// File: tb/tb_frame_reader.sv
// Scoreboard bench for frame_reader: three instances (4x3, 1x1, 128x160), memory content
// is {y, x}. Expected raster beats are queued at start; a negedge monitor pops and compares.
module tb_frame_reader;

  logic clk_24 = 1'b0;
  always #5 clk_24 = ~clk_24;

  logic rst;
  logic start_a, start_b, start_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;

  frame_reader_if #(.PIX_W(16)) if_a ();
  frame_reader_if #(.PIX_W(16)) if_b ();
  frame_reader_if #(.PIX_W(16)) if_c ();

  assign if_a.ram_data = {if_a.ram_addr_y, if_a.ram_addr_x};
  assign if_b.ram_data = {if_b.ram_addr_y, if_b.ram_addr_x};
  assign if_c.ram_data = {if_c.ram_addr_y, if_c.ram_addr_x};

  frame_reader #(.WIDTH(4), .HEIGHT(3), .PIX_W(16)) dut_a (
    .clk_24(clk_24), .rst(rst), .start(start_a), .bus(if_a), .busy(busy_a), .frame_done(done_a)
  );
  frame_reader #(.WIDTH(1), .HEIGHT(1), .PIX_W(16)) dut_b (
    .clk_24(clk_24), .rst(rst), .start(start_b), .bus(if_b), .busy(busy_b), .frame_done(done_b)
  );
  frame_reader #(.WIDTH(128), .HEIGHT(160), .PIX_W(16)) dut_c (
    .clk_24(clk_24), .rst(rst), .start(start_c), .bus(if_c), .busy(busy_c), .frame_done(done_c)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Beat = {data[15:0], sof, eol, eof}
  logic [18:0] q_a[$];
  logic [18:0] q_b[$];
  logic [18:0] q_c[$];
  int pending[3];
  int accepted[3];
  int dones[3];
  logic stall_q[3];
  logic [34:0] snap_q[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string detail);
    n_checks++;
    n_err++;
    $display("FAIL %s: %s (t=%0t)", name, detail, $time);
  endtask

  function automatic int q_size(input int id);
    case (id)
      0: return q_a.size();
      1: return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  function automatic logic [18:0] q_pop(input int id);
    case (id)
      0: return q_a.pop_front();
      1: return q_b.pop_front();
      default: return q_c.pop_front();
    endcase
  endfunction

  function automatic void q_push(input int id, input logic [18:0] e);
    case (id)
      0: q_a.push_back(e);
      1: q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endfunction

  function automatic logic done_of(input int id);
    case (id)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  // Reference: a frame is every (x, y) in raster order, pixel value {y, x}.
  task automatic push_frame(input int id, input int w, input int h);
    logic [18:0] e;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        e = {8'(y), 8'(x), (x == 0 && y == 0), (x == w - 1), (x == w - 1 && y == h - 1)};
        q_push(id, e);
      end
    end
    pending[id]++;
  endtask

  task automatic mon(input int id, input logic v, input logic r, input logic [18:0] beat,
                     input logic [7:0] ax, input logic [7:0] ay, input logic done);
    logic [18:0] e;
    if (stall_q[id]) begin
      chk($sformatf("stall_valid%0d", id), v, 1'b1);
      chk($sformatf("stall_hold%0d", id), {beat, ax, ay}, snap_q[id]);
    end
    stall_q[id] = v && !r;
    snap_q[id]  = {beat, ax, ay};
    if (v && r) begin
      accepted[id]++;
      if (q_size(id) == 0) begin
        fail($sformatf("extra_beat%0d", id), $sformatf("unexpected beat 0x%0h", beat));
      end else begin
        e = q_pop(id);
        chk($sformatf("beat%0d", id), beat, e);
      end
    end
    if (done) begin
      dones[id]++;
      chk($sformatf("done_expected%0d", id), {pending[id] > 0, q_size(id) == 0}, 2'b11);
      if (pending[id] > 0) pending[id]--;
    end
  endtask

  always @(negedge clk_24) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) stall_q[i] = 1'b0;
    end else begin
      mon(0, if_a.pix_valid, if_a.pix_ready,
          {if_a.pix_data, if_a.pix_sof, if_a.pix_eol, if_a.pix_eof},
          if_a.ram_addr_x, if_a.ram_addr_y, done_a);
      mon(1, if_b.pix_valid, if_b.pix_ready,
          {if_b.pix_data, if_b.pix_sof, if_b.pix_eol, if_b.pix_eof},
          if_b.ram_addr_x, if_b.ram_addr_y, done_b);
      mon(2, if_c.pix_valid, if_c.pix_ready,
          {if_c.pix_data, if_c.pix_sof, if_c.pix_eol, if_c.pix_eof},
          if_c.ram_addr_x, if_c.ram_addr_y, done_c);
    end
  end

  task automatic tick();
    @(posedge clk_24);
    #1;
  endtask

  task automatic wait_done(input int id, input int budget, input bit rnd, output int k);
    bit seen;
    seen = 1'b0;
    k = 0;
    while (!seen && k < budget) begin
      tick();
      k++;
      seen = done_of(id);
      if (rnd) if_c.pix_ready = 1'($urandom_range(0, 1));
    end
    if (!seen) fail($sformatf("done_timeout%0d", id), "frame_done never asserted");
  endtask

  logic [40:0] outs_a;
  assign outs_a = {if_a.ram_addr_x, if_a.ram_addr_y, if_a.pix_data, if_a.pix_valid,
                   if_a.pix_sof, if_a.pix_eol, if_a.pix_eof, busy_a, done_a};

  initial begin
    int  k;
    int  acc0;
    int  dones0;
    bit  found;

    for (int i = 0; i < 3; i++) begin
      pending[i] = 0; accepted[i] = 0; dones[i] = 0; stall_q[i] = 1'b0; snap_q[i] = '0;
    end
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    if_a.pix_ready = 1'b1; if_b.pix_ready = 1'b1; if_c.pix_ready = 1'b1;
    #12;
    chk("reset_outputs_a", outs_a, '0);
    chk("reset_busy_bc", {busy_b, busy_c, if_b.pix_valid, if_c.pix_valid}, 4'b0);
    #3 rst = 1'b0;
    tick();

    // Basic 4x3 frame, latency and flags.
    start_a = 1'b1;
    push_frame(0, 4, 3);
    tick();
    start_a = 1'b0;
    chk("busy_after_start", busy_a, 1'b1);
    chk("valid_before_first", if_a.pix_valid, 1'b0);
    tick();
    chk("first_pixel", {if_a.pix_valid, if_a.pix_data, if_a.pix_sof}, {1'b1, 16'h0000, 1'b1});
    wait_done(0, 40, 1'b0, k);
    chk("done_latency", k, 12);
    chk("busy_at_done", busy_a, 1'b0);
    tick();
    chk("done_one_cycle", done_a, 1'b0);

    // Stall three cycles on pixel 0x0102.
    acc0 = accepted[0];
    start_a = 1'b1;
    push_frame(0, 4, 3);
    tick();
    start_a = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      found = if_a.pix_valid && (if_a.pix_data == 16'h0102);
    end
    if (!found) fail("stall_setup", "pixel 0x0102 never presented");
    if_a.pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_data", {if_a.pix_valid, if_a.pix_data, if_a.pix_sof, if_a.pix_eol, if_a.pix_eof},
          {1'b1, 16'h0102, 3'b000});
      chk("stall_addr", {if_a.ram_addr_y, if_a.ram_addr_x}, 16'h0103);
    end
    if_a.pix_ready = 1'b1;
    tick();
    chk("after_stall", {if_a.pix_data, if_a.pix_eol}, {16'h0103, 1'b1});
    wait_done(0, 40, 1'b0, k);
    chk("stall_transfers", accepted[0] - acc0, 12);

    // start held across a whole frame; restart only from IDLE.
    tick();
    start_a = 1'b1;
    push_frame(0, 4, 3);
    wait_done(0, 40, 1'b0, k);
    chk("start_ignored_at_done", busy_a, 1'b0);
    @(negedge clk_24);
    #1;
    push_frame(0, 4, 3);
    tick();
    start_a = 1'b0;
    chk("restart_fetch", {busy_a, if_a.pix_valid}, 2'b10);
    tick();
    chk("restart_first", {if_a.pix_valid, if_a.pix_data, if_a.pix_sof}, {1'b1, 16'h0000, 1'b1});
    wait_done(0, 40, 1'b0, k);

    // 1x1 frame.
    start_b = 1'b1;
    push_frame(1, 1, 1);
    tick();
    start_b = 1'b0;
    tick();
    chk("single_flags", {if_b.pix_valid, if_b.pix_sof, if_b.pix_eol, if_b.pix_eof}, 4'b1111);
    chk("single_drain_addr", {if_b.ram_addr_x, if_b.ram_addr_y}, 16'h0000);
    wait_done(1, 10, 1'b0, k);
    chk("single_done_latency", k, 1);
    chk("single_idle", {busy_b, if_b.pix_valid, if_b.ram_addr_x, if_b.ram_addr_y}, '0);

    // Asynchronous reset mid-frame at pixel 5 (0x0101).
    tick();
    start_a = 1'b1;
    push_frame(0, 4, 3);
    tick();
    start_a = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      found = if_a.pix_valid && (if_a.pix_data == 16'h0101);
    end
    if (!found) fail("abort_setup", "pixel 0x0101 never presented");
    @(negedge clk_24);
    #2;
    dones0 = dones[0];
    rst = 1'b1;
    #1;
    chk("abort_outputs", outs_a, '0);
    q_a.delete();
    pending[0] = 0;
    #10 rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("abort_no_done", dones[0], dones0);
    start_a = 1'b1;
    push_frame(0, 4, 3);
    tick();
    start_a = 1'b0;
    wait_done(0, 40, 1'b0, k);

    // 128x160 with random backpressure.
    start_c = 1'b1;
    push_frame(2, 128, 160);
    tick();
    start_c = 1'b0;
    wait_done(2, 60000, 1'b1, k);
    for (int i = 0; i < 50; i++) begin
      tick();
      if_c.pix_ready = 1'($urandom_range(0, 1));
    end
    chk("big_done_once", dones[2], 1);
    chk("big_accepted", accepted[2], 128 * 160);
    if_c.pix_ready = 1'b1;

    tick();
    chk("queues_empty", q_a.size() + q_b.size() + q_c.size(), 0);
    chk("frames_pending", pending[0] + pending[1] + pending[2], 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
